// File: rtl/adaptive_rtpg_pkg.sv
// Shared definitions for the adaptive random test-pattern generation controller:
// FSM state encodings, done_reason codes and the expected-fault-count update.
package adaptive_rtpg_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE    = 3'd0;
    localparam state_t S_GEN     = 3'd1;
    localparam state_t S_ISSUE   = 3'd2;
    localparam state_t S_COLLECT = 3'd3;
    localparam state_t S_DECIDE  = 3'd4;
    localparam state_t S_COMMIT  = 3'd5;
    localparam state_t S_EMIT    = 3'd6;
    localparam state_t S_DONE    = 3'd7;

    localparam logic [1:0] RSN_NONE  = 2'b00;
    localparam logic [1:0] RSN_COV   = 2'b01;
    localparam logic [1:0] RSN_UT    = 2'b10;
    localparam logic [1:0] RSN_PROTO = 2'b11;

    // Adaptive update of the expected-new-fault count. The sum is formed one
    // bit wider than the operands so the halving never loses the carry.
    function automatic logic [31:0] next_exp(input logic [31:0] new_cnt,
                                             input logic [31:0] exp_cnt);
        logic [32:0] sum;
        sum = {1'b0, new_cnt} + {1'b0, exp_cnt};
        if (new_cnt < exp_cnt) begin
            return exp_cnt >> 1;
        end
        return sum[32:1];
    endfunction

endpackage

// File: rtl/adaptive_rtpg_ctrl_if.sv
// Candidate, detection-stream and kept-vector signals between the controller
// (master) and the fault-sim engine / test-file writer (slave).
interface adaptive_rtpg_ctrl_if #(
    parameter int VEC_W = 50
);
    logic [VEC_W-1:0] vec;
    logic             vec_valid;
    logic             vec_ready;
    logic             det_valid;
    logic             det_hit;
    logic             det_last;
    logic [VEC_W-1:0] kept_vec;
    logic             kept_valid;
    logic             kept_ready;

    modport master (
        output vec, vec_valid, kept_vec, kept_valid,
        input  vec_ready, det_valid, det_hit, det_last, kept_ready
    );

    modport slave (
        input  vec, vec_valid, kept_vec, kept_valid,
        output vec_ready, det_valid, det_hit, det_last, kept_ready
    );
endinterface

// File: rtl/rtpg_lfsr.sv
// Right-shifting Galois LFSR with synchronous seed load and step enable.
// An all-zero seed is replaced by 1 so the register never locks up.
module rtpg_lfsr #(
    parameter int               WIDTH = 50,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(50'h3000000C00000)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             step,
    output logic [WIDTH-1:0] state
);
    logic [WIDTH-1:0] state_q, state_d;

    // Next state: seed load has priority over stepping.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = (seed == '0) ? WIDTH'(1) : seed;
        end else if (step) begin
            state_d = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;
endmodule

// File: rtl/adaptive_rtpg_ctrl.sv
// Adaptive RTPG controller: generates LFSR candidates, collects the per-fault
// detection stream, keeps or discards each candidate against the adaptive
// expected-new-fault count, and stops on coverage or a useless-test limit.
module adaptive_rtpg_ctrl
    import adaptive_rtpg_pkg::*;
#(
    parameter int               VEC_W      = 50,
    parameter int               NUM_FAULTS = 2230,
    parameter int               FIDX_W     = $clog2(NUM_FAULTS + 1),
    parameter int               INIT_EXP   = 10,
    parameter int               UT_LIMIT   = 20,
    parameter int               COV_PCT    = 90,
    parameter logic [VEC_W-1:0] TAPS       = VEC_W'(50'h3000000C00000)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [VEC_W-1:0]     seed,
    adaptive_rtpg_ctrl_if.master bus,
    output logic [FIDX_W-1:0]    exp_cnt,
    output logic [FIDX_W-1:0]    det_total,
    output logic [15:0]          kept_cnt,
    output logic [15:0]          total_cnt,
    output logic [7:0]           ut_cnt,
    output logic                 done,
    output logic [1:0]           done_reason
);
    localparam int          BIT_W   = (NUM_FAULTS > 1) ? $clog2(NUM_FAULTS) : 1;
    localparam int          GCNT_W  = $clog2(VEC_W + 1);
    localparam logic [31:0] COV_RHS = 32'(COV_PCT * NUM_FAULTS);

    state_t                state_q, state_d;
    logic [GCNT_W-1:0]     gen_cnt_q, gen_cnt_d;
    logic [FIDX_W-1:0]     idx_q, idx_d;
    logic [FIDX_W-1:0]     new_cnt_q, new_cnt_d;
    logic [FIDX_W-1:0]     exp_cnt_q, exp_cnt_d;
    logic [FIDX_W-1:0]     det_total_q, det_total_d;
    logic [15:0]           kept_cnt_q, kept_cnt_d;
    logic [15:0]           total_cnt_q, total_cnt_d;
    logic [7:0]            ut_cnt_q, ut_cnt_d;
    logic [1:0]            done_reason_q, done_reason_d;
    logic [NUM_FAULTS-1:0] cand_q, cand_d;
    logic [NUM_FAULTS-1:0] acc_q, acc_d;
    logic [VEC_W-1:0]      kept_vec_q, kept_vec_d;

    logic                  lfsr_load, lfsr_step;
    logic [VEC_W-1:0]      lfsr_state;
    logic [BIT_W-1:0]      bidx;
    logic [FIDX_W-1:0]     exp_next;
    logic                  keep;
    logic                  cov_hit;
    logic                  stop_eval;
    logic [7:0]            ut_chk;

    rtpg_lfsr #(
        .WIDTH (VEC_W),
        .TAPS  (TAPS)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lfsr_load),
        .seed  (seed),
        .step  (lfsr_step),
        .state (lfsr_state)
    );

    // Decision terms shared by DECIDE and the stop check.
    always_comb begin
        bidx     = idx_q[BIT_W-1:0];
        exp_next = FIDX_W'(next_exp(32'(new_cnt_q), 32'(exp_cnt_q)));
        keep     = (new_cnt_q >= exp_next) && (new_cnt_q != '0);
        cov_hit  = ((32'(det_total_q) * 32'd100) >= COV_RHS);
    end

    // FSM next-state and datapath updates; stop conditions are evaluated after
    // a discard in DECIDE or after the kept vector is accepted in EMIT.
    always_comb begin
        state_d       = state_q;
        gen_cnt_d     = gen_cnt_q;
        idx_d         = idx_q;
        new_cnt_d     = new_cnt_q;
        exp_cnt_d     = exp_cnt_q;
        det_total_d   = det_total_q;
        kept_cnt_d    = kept_cnt_q;
        total_cnt_d   = total_cnt_q;
        ut_cnt_d      = ut_cnt_q;
        done_reason_d = done_reason_q;
        cand_d        = cand_q;
        acc_d         = acc_q;
        kept_vec_d    = kept_vec_q;
        lfsr_load     = 1'b0;
        lfsr_step     = 1'b0;
        stop_eval     = 1'b0;
        ut_chk        = ut_cnt_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    cand_d        = '0;
                    acc_d         = '0;
                    idx_d         = '0;
                    new_cnt_d     = '0;
                    det_total_d   = '0;
                    kept_cnt_d    = '0;
                    total_cnt_d   = '0;
                    ut_cnt_d      = '0;
                    gen_cnt_d     = '0;
                    done_reason_d = RSN_NONE;
                    exp_cnt_d     = FIDX_W'(INIT_EXP);
                    lfsr_load     = 1'b1;
                    state_d       = S_GEN;
                end
            end
            S_GEN: begin
                // VEC_W steps, then one more cycle to settle before issuing.
                if (gen_cnt_q == GCNT_W'(VEC_W)) begin
                    state_d = S_ISSUE;
                end else begin
                    lfsr_step = 1'b1;
                    gen_cnt_d = gen_cnt_q + GCNT_W'(1);
                end
            end
            S_ISSUE: begin
                if (bus.vec_ready) begin
                    idx_d   = '0;
                    state_d = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (bus.det_valid) begin
                    if (bus.det_hit) begin
                        cand_d[bidx] = 1'b1;
                        if (!acc_q[bidx]) begin
                            new_cnt_d = new_cnt_q + FIDX_W'(1);
                        end
                    end
                    if (bus.det_last) begin
                        if (idx_q == FIDX_W'(NUM_FAULTS - 1)) begin
                            state_d = S_DECIDE;
                        end else begin
                            done_reason_d = RSN_PROTO;
                            state_d       = S_DONE;
                        end
                    end else if (idx_q == FIDX_W'(NUM_FAULTS - 1)) begin
                        done_reason_d = RSN_PROTO;
                        state_d       = S_DONE;
                    end else begin
                        idx_d = idx_q + FIDX_W'(1);
                    end
                end
            end
            S_DECIDE: begin
                exp_cnt_d   = exp_next;
                total_cnt_d = total_cnt_q + 16'd1;
                if (keep) begin
                    kept_cnt_d = kept_cnt_q + 16'd1;
                    ut_cnt_d   = '0;
                    state_d    = S_COMMIT;
                end else begin
                    ut_cnt_d  = ut_cnt_q + 8'd1;
                    ut_chk    = ut_cnt_q + 8'd1;
                    stop_eval = 1'b1;
                end
            end
            S_COMMIT: begin
                acc_d       = acc_q | cand_q;
                det_total_d = det_total_q + new_cnt_q;
                kept_vec_d  = lfsr_state;
                state_d     = S_EMIT;
            end
            S_EMIT: begin
                if (bus.kept_ready) begin
                    stop_eval = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (stop_eval) begin
            if (cov_hit) begin
                done_reason_d = RSN_COV;
                state_d       = S_DONE;
            end else if (ut_chk >= 8'(UT_LIMIT)) begin
                done_reason_d = RSN_UT;
                state_d       = S_DONE;
            end else begin
                cand_d    = '0;
                new_cnt_d = '0;
                gen_cnt_d = '0;
                state_d   = S_GEN;
            end
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            gen_cnt_q     <= '0;
            idx_q         <= '0;
            new_cnt_q     <= '0;
            exp_cnt_q     <= FIDX_W'(INIT_EXP);
            det_total_q   <= '0;
            kept_cnt_q    <= '0;
            total_cnt_q   <= '0;
            ut_cnt_q      <= '0;
            done_reason_q <= RSN_NONE;
            cand_q        <= '0;
            acc_q         <= '0;
            kept_vec_q    <= '0;
        end else begin
            state_q       <= state_d;
            gen_cnt_q     <= gen_cnt_d;
            idx_q         <= idx_d;
            new_cnt_q     <= new_cnt_d;
            exp_cnt_q     <= exp_cnt_d;
            det_total_q   <= det_total_d;
            kept_cnt_q    <= kept_cnt_d;
            total_cnt_q   <= total_cnt_d;
            ut_cnt_q      <= ut_cnt_d;
            done_reason_q <= done_reason_d;
            cand_q        <= cand_d;
            acc_q         <= acc_d;
            kept_vec_q    <= kept_vec_d;
        end
    end

    assign bus.vec        = lfsr_state;
    assign bus.vec_valid  = (state_q == S_ISSUE);
    assign bus.kept_vec   = kept_vec_q;
    assign bus.kept_valid = (state_q == S_EMIT);
    assign exp_cnt        = exp_cnt_q;
    assign det_total      = det_total_q;
    assign kept_cnt       = kept_cnt_q;
    assign total_cnt      = total_cnt_q;
    assign ut_cnt         = ut_cnt_q;
    assign done           = (state_q == S_DONE);
    assign done_reason    = done_reason_q;
endmodule

// File: tb/tb_adaptive_rtpg_ctrl.sv
// Directed bench for adaptive_rtpg_ctrl: an 8-fault instance for the main
// scenarios and a 16-fault instance for the large-keep case.
module tb_adaptive_rtpg_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start8, start16;
    logic [7:0] seed8, seed16;
    logic       vec_ready, det_valid, det_hit, det_last, kept_ready;

    logic [3:0]  exp8, tot8;
    logic [4:0]  exp16, tot16;
    logic [15:0] kc8, tc8, kc16, tc16;
    logic [7:0]  ut8, ut16;
    logic        done8, done16;
    logic [1:0]  rs8, rs16;

    int checks = 0;
    int passes = 0;

    adaptive_rtpg_ctrl_if #(.VEC_W(8)) if8 ();
    adaptive_rtpg_ctrl_if #(.VEC_W(8)) if16 ();

    assign if8.vec_ready   = vec_ready;
    assign if8.det_valid   = det_valid;
    assign if8.det_hit     = det_hit;
    assign if8.det_last    = det_last;
    assign if8.kept_ready  = kept_ready;
    assign if16.vec_ready  = vec_ready;
    assign if16.det_valid  = det_valid;
    assign if16.det_hit    = det_hit;
    assign if16.det_last   = det_last;
    assign if16.kept_ready = kept_ready;

    adaptive_rtpg_ctrl #(
        .VEC_W(8), .NUM_FAULTS(8), .INIT_EXP(10), .UT_LIMIT(3), .COV_PCT(75), .TAPS(8'hB8)
    ) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .seed(seed8), .bus(if8.master),
        .exp_cnt(exp8), .det_total(tot8), .kept_cnt(kc8), .total_cnt(tc8),
        .ut_cnt(ut8), .done(done8), .done_reason(rs8)
    );

    adaptive_rtpg_ctrl #(
        .VEC_W(8), .NUM_FAULTS(16), .INIT_EXP(10), .UT_LIMIT(3), .COV_PCT(75), .TAPS(8'hB8)
    ) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .seed(seed16), .bus(if16.master),
        .exp_cnt(exp16), .det_total(tot16), .kept_cnt(kc16), .total_cnt(tc16),
        .ut_cnt(ut16), .done(done16), .done_reason(rs16)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input bit s16, input logic [7:0] sd);
        if (s16) begin seed16 = sd; start16 = 1'b1; end
        else begin seed8 = sd; start8 = 1'b1; end
        tick();
        start8  = 1'b0;
        start16 = 1'b0;
    endtask

    // Bounded wait for a candidate, then accept it with a one-cycle vec_ready.
    task automatic take_vec(input bit s16, output bit ok, output logic [7:0] v);
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if ((s16 ? if16.vec_valid : if8.vec_valid) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        v = s16 ? if16.vec : if8.vec;
        if (ok) begin
            vec_ready = 1'b1;
            tick();
            vec_ready = 1'b0;
        end
    endtask

    // Stream n results (bit i of hits), with one stall cycle before result 2.
    task automatic feed(input logic [15:0] hits, input int n, input int last_at);
        for (int i = 0; i < n; i++) begin
            if (i == 2) begin
                det_valid = 1'b0; det_hit = 1'b1; det_last = 1'b0;
                tick();
            end
            det_valid = 1'b1;
            det_hit   = hits[i];
            det_last  = (i == last_at);
            tick();
            if (i == last_at) break;
        end
        det_valid = 1'b0; det_hit = 1'b0; det_last = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        checks++; if (if8.vec !== 8'h00) $display("FAIL reset_vec: got %0h want 0", if8.vec); else passes++;
        checks++; if (if8.vec_valid !== 1'b0) $display("FAIL reset_vec_valid: got %0b want 0", if8.vec_valid); else passes++;
        checks++; if (if8.kept_valid !== 1'b0) $display("FAIL reset_kept_valid: got %0b want 0", if8.kept_valid); else passes++;
        checks++; if (if8.kept_vec !== 8'h00) $display("FAIL reset_kept_vec: got %0h want 0", if8.kept_vec); else passes++;
        checks++; if (exp8 !== 4'd10) $display("FAIL reset_exp: got %0d want 10", exp8); else passes++;
        checks++; if ({tot8, kc8, tc8, ut8} !== '0) $display("FAIL reset_counters: got %0h want 0", {tot8, kc8, tc8, ut8}); else passes++;
        checks++; if ({done8, rs8} !== 3'b000) $display("FAIL reset_done: got %0b want 000", {done8, rs8}); else passes++;
        checks++; if (exp16 !== 5'd10) $display("FAIL reset_exp16: got %0d want 10", exp16); else passes++;
    endtask

    task automatic test_start_latency();
        int n;
        start_run(1'b0, 8'h00);
        n = 0;
        while (if8.vec_valid !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        checks++; if (n !== 9) $display("FAIL start_latency: got %0d cycles want 9", n); else passes++;
        // Seed 0 behaves as seed 1; eight Galois steps with mask B8 give 64.
        checks++; if (if8.vec !== 8'h64) $display("FAIL first_vec: got %0h want 64", if8.vec); else passes++;
        tick(); tick();
        checks++; if (if8.vec !== 8'h64 || if8.vec_valid !== 1'b1) $display("FAIL vec_hold: got %0h/%0b want 64/1", if8.vec, if8.vec_valid); else passes++;
    endtask

    task automatic test_discard();
        bit ok;
        logic [7:0] v;
        take_vec(1'b0, ok, v);
        checks++; if (ok !== 1'b1) $display("FAIL discard_vec_timeout: got %0b want 1", ok); else passes++;
        feed(16'h0007, 8, 7);
        tick();
        checks++; if (exp8 !== 4'd5) $display("FAIL discard_exp: got %0d want 5", exp8); else passes++;
        checks++; if (ut8 !== 8'd1 || tc8 !== 16'd1 || kc8 !== 16'd0) $display("FAIL discard_counts: got ut=%0d tot=%0d kept=%0d want 1/1/0", ut8, tc8, kc8); else passes++;
        tick();
        checks++; if (if8.kept_valid !== 1'b0) $display("FAIL discard_kept_valid: got %0b want 0", if8.kept_valid); else passes++;
    endtask

    task automatic test_useless_limit();
        bit ok;
        logic [7:0] v;
        logic [3:0] exp_tab [3];
        exp_tab = '{4'd5, 4'd2, 4'd1};
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        start_run(1'b0, 8'h3C);
        for (int j = 0; j < 3; j++) begin
            take_vec(1'b0, ok, v);
            checks++; if (ok !== 1'b1) $display("FAIL ut_vec_timeout%0d: got %0b want 1", j, ok); else passes++;
            feed(16'h0000, 8, 7);
            tick();
            checks++; if (exp8 !== exp_tab[j]) $display("FAIL ut_exp%0d: got %0d want %0d", j, exp8, exp_tab[j]); else passes++;
            // start during GEN must not restart the run
            if (j == 0) start_run(1'b0, 8'hFF);
        end
        checks++; if (done8 !== 1'b1 || rs8 !== 2'b10) $display("FAIL ut_done: got %0b/%0b want 1/10", done8, rs8); else passes++;
        checks++; if (tc8 !== 16'd3 || ut8 !== 8'd3) $display("FAIL ut_counts: got tot=%0d ut=%0d want 3/3", tc8, ut8); else passes++;
    endtask

    task automatic test_coverage();
        bit ok;
        logic [7:0] v;
        start_run(1'b0, 8'h5A);
        checks++; if (done8 !== 1'b0 || tc8 !== 16'd0 || exp8 !== 4'd10) $display("FAIL restart: got done=%0b tot=%0d exp=%0d want 0/0/10", done8, tc8, exp8); else passes++;
        take_vec(1'b0, ok, v);
        feed(16'h0000, 8, 7);
        tick();
        checks++; if (exp8 !== 4'd5) $display("FAIL cov_exp1: got %0d want 5", exp8); else passes++;
        take_vec(1'b0, ok, v);
        checks++; if (ok !== 1'b1) $display("FAIL cov_vec_timeout: got %0b want 1", ok); else passes++;
        feed(16'h000F, 8, 7);
        tick();
        checks++; if (exp8 !== 4'd2 || if8.kept_valid !== 1'b0) $display("FAIL cov_decide2: got exp=%0d kv=%0b want 2/0", exp8, if8.kept_valid); else passes++;
        tick();
        checks++; if (if8.kept_valid !== 1'b1 || if8.kept_vec !== v) $display("FAIL cov_emit2: got kv=%0b vec=%0h want 1/%0h", if8.kept_valid, if8.kept_vec, v); else passes++;
        checks++; if (tot8 !== 4'd4 || kc8 !== 16'd1 || ut8 !== 8'd0) $display("FAIL cov_counts2: got det=%0d kept=%0d ut=%0d want 4/1/0", tot8, kc8, ut8); else passes++;
        tick(); tick();
        checks++; if (if8.kept_valid !== 1'b1 || if8.kept_vec !== v) $display("FAIL cov_kept_hold: got kv=%0b vec=%0h want 1/%0h", if8.kept_valid, if8.kept_vec, v); else passes++;
        kept_ready = 1'b1; tick(); kept_ready = 1'b0;
        checks++; if (if8.kept_valid !== 1'b0 || done8 !== 1'b0) $display("FAIL cov_continue: got kv=%0b done=%0b want 0/0", if8.kept_valid, done8); else passes++;
        take_vec(1'b0, ok, v);
        feed(16'h003F, 8, 7);
        tick();
        checks++; if (exp8 !== 4'd2) $display("FAIL cov_exp3: got %0d want 2", exp8); else passes++;
        tick();
        checks++; if (if8.kept_valid !== 1'b1 || tot8 !== 4'd6) $display("FAIL cov_emit3: got kv=%0b det=%0d want 1/6", if8.kept_valid, tot8); else passes++;
        checks++; if (done8 !== 1'b0) $display("FAIL cov_done_early: got %0b want 0", done8); else passes++;
        kept_ready = 1'b1; tick(); kept_ready = 1'b0;
        checks++; if (done8 !== 1'b1 || rs8 !== 2'b01) $display("FAIL cov_done: got %0b/%0b want 1/01", done8, rs8); else passes++;
        checks++; if (kc8 !== 16'd2 || tc8 !== 16'd3) $display("FAIL cov_counts3: got kept=%0d tot=%0d want 2/3", kc8, tc8); else passes++;
    endtask

    task automatic test_protocol();
        bit ok;
        logic [7:0] v;
        start_run(1'b0, 8'h11);
        take_vec(1'b0, ok, v);
        feed(16'h00FF, 8, 4);
        checks++; if (done8 !== 1'b1 || rs8 !== 2'b11) $display("FAIL proto_early_last: got %0b/%0b want 1/11", done8, rs8); else passes++;
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        checks++; if (done8 !== 1'b0 || rs8 !== 2'b00 || exp8 !== 4'd10 || tc8 !== 16'd0) $display("FAIL proto_reset: got done=%0b rs=%0b exp=%0d tot=%0d want 0/00/10/0", done8, rs8, exp8, tc8); else passes++;
        start_run(1'b0, 8'h22);
        take_vec(1'b0, ok, v);
        feed(16'h0000, 8, -1);
        checks++; if (done8 !== 1'b1 || rs8 !== 2'b11) $display("FAIL proto_missing_last: got %0b/%0b want 1/11", done8, rs8); else passes++;
    endtask

    task automatic test_keep16();
        bit ok;
        logic [7:0] v;
        start_run(1'b1, 8'hA5);
        take_vec(1'b1, ok, v);
        checks++; if (ok !== 1'b1) $display("FAIL keep_vec_timeout: got %0b want 1", ok); else passes++;
        feed(16'h0FFF, 16, 15);
        tick();
        checks++; if (exp16 !== 5'd11) $display("FAIL keep_exp: got %0d want 11", exp16); else passes++;
        tick();
        checks++; if (if16.kept_valid !== 1'b1 || if16.kept_vec !== v) $display("FAIL keep_emit: got kv=%0b vec=%0h want 1/%0h", if16.kept_valid, if16.kept_vec, v); else passes++;
        checks++; if (tot16 !== 5'd12 || kc16 !== 16'd1) $display("FAIL keep_counts: got det=%0d kept=%0d want 12/1", tot16, kc16); else passes++;
        kept_ready = 1'b1; tick(); kept_ready = 1'b0;
        checks++; if (done16 !== 1'b1 || rs16 !== 2'b01) $display("FAIL keep_done: got %0b/%0b want 1/01", done16, rs16); else passes++;
    endtask

    initial begin
        rst_n = 1'b0; start8 = 1'b0; start16 = 1'b0; seed8 = '0; seed16 = '0;
        vec_ready = 1'b0; det_valid = 1'b0; det_hit = 1'b0; det_last = 1'b0; kept_ready = 1'b0;
        test_reset();
        test_start_latency();
        test_discard();
        test_useless_limit();
        test_coverage();
        test_protocol();
        test_keep16();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
